encoder_83_seq: RTL and testbench
=================================

Name: encoder_83_seq

Overview:
- Sequential 8-to-3 priority encoder. It is the inverse partner of the team's 3-to-8 decoder and uses the same enable code, en_i == 3'b100.
- It captures an 8-bit request vector and emits the 3-bit index of each set bit, one per valid/ready handshake, in priority order.
- It reports completion with done_o and an empty capture with none_o.
- It sits between request sources (switches, interrupt lines) and a downstream consumer, which may feed the emitted index back into the decoder.

Parameters:
- MSB_FIRST, default 1: 1 means bit 7 has the highest priority and is emitted first (74148-style); 0 means bit 0 is emitted first.

Ports:
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_n_i  input  1  synchronous, active-low reset, sampled on the rising edge of clk_i.
- en_i  input  3  enable code; the block is enabled only when en_i == 3'b100.
- load_i  input  1  capture request for data_i; honoured only in IDLE while enabled.
- data_i  input  8  request vector; bit n set means index n is pending.
- ready_i  input  1  consumer accepts data_o this cycle.
- data_o  output  3  index of the current highest-priority pending bit.
- valid_o  output  1  data_o is valid.
- busy_o  output  1  high while in EMIT state.
- done_o  output  1  one-cycle pulse after the last index is accepted.
- none_o  output  1  one-cycle pulse after a load of an all-zero vector.

Behaviour:
- States: IDLE and EMIT. Internal register pend[7:0].
- All outputs are registered.
- Reset (rst_n_i == 0 at an edge):
  - state = IDLE, pend = 8'h00;
  - data_o = 3'b000, valid_o = 0, busy_o = 0, done_o = 0, none_o = 0.
  - Reset overrides every other input at that edge, including mid-EMIT; no done_o is produced.
- "Enabled" means en_i == 3'b100. Every other en_i value counts as disabled.
- IDLE:
  - Enabled, load_i = 1, data_i != 0: pend <= data_i, state <= EMIT. At that same edge, valid_o <= 1, busy_o <= 1, and data_o <= priority index of data_i. First index is therefore visible 1 cycle after load.
  - Enabled, load_i = 1, data_i == 0: none_o pulses high for exactly the next cycle; state stays IDLE.
  - Disabled, or load_i = 0: no change.
  - In IDLE, data_o holds 3'b000.
- EMIT:
  - valid_o = 1.
  - data_o = index of the highest-priority set bit of pend. With MSB_FIRST = 1 that is the highest set bit; with MSB_FIRST = 0 it is the lowest set bit.
  - When valid_o && ready_i at an edge, that bit is cleared in pend.
    - If pend becomes 0: state <= IDLE, valid_o <= 0, busy_o <= 0, data_o <= 3'b000, and done_o pulses for exactly 1 cycle.
    - Otherwise data_o <= next index at that edge, so back-to-back handshakes give one index per cycle.
  - Backpressure: while ready_i = 0, data_o and pend hold stable.
  - load_i is ignored in EMIT. New data_i does not disturb pend.
  - Disabled in EMIT: abort at that edge. pend <= 0, state <= IDLE, valid_o <= 0, busy_o <= 0, data_o <= 3'b000, no done_o. This holds even if ready_i = 1 at that edge.
- Single-bit load: exactly one handshake, then done_o.
- 8'hFF load: 8 handshakes, in order 7..0 (MSB_FIRST = 1) or 0..7 (MSB_FIRST = 0).
- done_o and none_o are never high in the same cycle and are never high while valid_o = 1.
- After done_o, the earliest next accepted load is the cycle done_o is high, because state is already IDLE by then.

Test Plan:
- Reset check: hold rst_n_i = 0 for 2 cycles with random inputs -> data_o = 3'b000 and valid_o = busy_o = done_o = none_o = 0. Repeat reset mid-EMIT after loading 8'hA5 -> back to IDLE, no done_o.
- Full vector, MSB_FIRST = 1: en_i = 3'b100, load 8'b1010_0110, ready_i held 1 -> data_o sequence 7, 5, 2, 1 on consecutive cycles; done_o one cycle after 1 is accepted. Repeat with MSB_FIRST = 0 -> 1, 2, 5, 7.
- Backpressure: load 8'h81, ready_i = 0 for 3 cycles -> data_o = 7 stable and valid_o = 1. Then ready_i = 1 -> data_o = 0 next cycle, then done_o. Change data_i and pulse load_i during EMIT -> no effect.
- Enable gating: en_i = 3'b000, 3'b110, 3'b101 with load 8'h10 -> no capture, valid_o stays 0. Load 8'hFF with en_i = 3'b100, then en_i = 3'b000 after 2 accepts -> valid_o = 0 next cycle, no done_o, data_o = 0.
- Empty load: en_i = 3'b100, load 8'h00 -> none_o high for exactly 1 cycle, valid_o stays 0, busy_o stays 0.
- Round trip: drive data_o into the 3-to-8 decoder (en_i = 3'b100) and OR the decoder outputs over all handshakes -> the result equals the loaded vector, for all 256 values.

Source files
------------

// File: rtl/encoder_83_seq.sv
// encoder_83_seq: sequential 8-to-3 priority encoder, one index per valid/ready handshake
//
// Captures an 8-bit request vector on load and then emits the index of every
// set bit, highest priority first, one per handshake.
//
// Ports:
//   clk_i    clock, rising edge
//   rst_n_i  synchronous active-low reset
//   en_i     enable code, active only when 3'b100
//   load_i   capture request for data_i (IDLE only)
//   data_i   request vector
//   ready_i  consumer accepts data_o
//   data_o   current priority index
//   valid_o  data_o valid
//   busy_o   high while emitting
//   done_o   one-cycle pulse after the last index is accepted
//   none_o   one-cycle pulse after loading an all-zero vector
module encoder_83_seq #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [2:0] en_i,
    input  logic       load_i,
    input  logic [7:0] data_i,
    input  logic       ready_i,
    output logic [2:0] data_o,
    output logic       valid_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       none_o
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EMIT = 1'b1;

    logic [0:0] state;
    logic [7:0] pend;
    logic [7:0] pend_nxt;
    logic       en;

    // Scan from lowest to highest priority so the last hit wins.
    function automatic logic [2:0] pick(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (MSB_FIRST ? v[i] : v[7 - i])
                idx = MSB_FIRST ? 3'(i) : 3'(7 - i);
        end
        return idx;
    endfunction

    assign en       = en_i == 3'b100;
    // data_o always names the bit being offered, so it is the one to clear.
    assign pend_nxt = pend & ~(8'd1 << data_o);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state   <= IDLE;
            pend    <= 8'h00;
            data_o  <= 3'b000;
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            none_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            none_o <= 1'b0;
            if (state == IDLE) begin
                if (en && load_i) begin
                    if (data_i != 8'h00) begin
                        pend    <= data_i;
                        state   <= EMIT;
                        valid_o <= 1'b1;
                        busy_o  <= 1'b1;
                        data_o  <= pick(data_i);
                    end else begin
                        none_o <= 1'b1;
                    end
                end
            end else if (!en) begin
                pend    <= 8'h00;
                state   <= IDLE;
                valid_o <= 1'b0;
                busy_o  <= 1'b0;
                data_o  <= 3'b000;
            end else if (ready_i) begin
                pend <= pend_nxt;
                if (pend_nxt == 8'h00) begin
                    state   <= IDLE;
                    valid_o <= 1'b0;
                    busy_o  <= 1'b0;
                    data_o  <= 3'b000;
                    done_o  <= 1'b1;
                end else begin
                    data_o <= pick(pend_nxt);
                end
            end
        end
    end
endmodule

// File: tb/tb_encoder_83_seq.sv
// tb_encoder_83_seq: directed self-checking bench for encoder_83_seq (both priority orders)
module tb_encoder_83_seq;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] en;
    logic       load;
    logic [7:0] data;
    logic       ready;
    logic [2:0] m_data, l_data;
    logic       m_valid, m_busy, m_done, m_none;
    logic       l_valid, l_busy, l_done, l_none;
    int         n_vec = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    encoder_83_seq #(.MSB_FIRST(1'b1)) dut_m (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .load_i(load), .data_i(data), .ready_i(ready),
        .data_o(m_data), .valid_o(m_valid), .busy_o(m_busy), .done_o(m_done), .none_o(m_none)
    );
    encoder_83_seq #(.MSB_FIRST(1'b0)) dut_l (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .load_i(load), .data_i(data), .ready_i(ready),
        .data_o(l_data), .valid_o(l_valid), .busy_o(l_busy), .done_o(l_done), .none_o(l_none)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] dec(input logic [2:0] e, input logic [2:0] idx);
        return e == 3'b100 ? 8'd1 << idx : 8'h00;
    endfunction

    initial begin
        int seq_m [4] = '{7, 5, 2, 1};
        int seq_l [4] = '{1, 2, 5, 7};
        logic [2:0] en_off [3] = '{3'b000, 3'b110, 3'b101};
        rst_n = 1'b0; en = 3'b100; load = 1'b1; data = 8'($urandom); ready = 1'($urandom);
        step();
        data = 8'($urandom); en = 3'($urandom);
        step();
        chk("reset_m", {m_data, m_valid, m_busy, m_done, m_none}, 0);
        chk("reset_l", {l_data, l_valid, l_busy, l_done, l_none}, 0);

        rst_n = 1'b1; en = 3'b100; load = 1'b1; data = 8'b1010_0110; ready = 1'b1;
        step();
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("seq_m%0d", i), {m_valid, m_busy, m_data}, {2'b11, 3'(seq_m[i])});
            chk($sformatf("seq_l%0d", i), {l_valid, l_busy, l_data}, {2'b11, 3'(seq_l[i])});
            chk("seq_nodone", {m_done, l_done}, 0);
            step();
        end
        chk("seq_done_m", {m_done, m_valid, m_busy, m_data}, 6'b100000);
        chk("seq_done_l", {l_done, l_valid, l_busy, l_data}, 6'b100000);
        step();
        chk("seq_done_pulse", {m_done, l_done}, 0);

        ready = 1'b0; load = 1'b1; data = 8'h81;
        step();
        data = 8'h0F;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_m", {m_valid, m_data}, {1'b1, 3'd7});
            chk("bp_l", {l_valid, l_data}, {1'b1, 3'd0});
        end
        load = 1'b0; ready = 1'b1;
        step();
        chk("bp_rel_m", {m_valid, m_data, m_done}, {1'b1, 3'd0, 1'b0});
        chk("bp_rel_l", {l_valid, l_data, l_done}, {1'b1, 3'd7, 1'b0});
        step();
        chk("bp_done", {m_done, l_done, m_valid, l_valid}, 4'b1100);

        foreach (en_off[k]) begin
            en = en_off[k]; load = 1'b1; data = 8'h10;
            step();
            chk($sformatf("gate_%0d", en_off[k]), {m_valid, m_busy, m_none, l_valid}, 0);
        end

        en = 3'b100; load = 1'b1; data = 8'hFF; ready = 1'b1;
        step();
        load = 1'b0;
        chk("abort_first", m_data, 7);
        step();
        step();
        chk("abort_pre", {m_data, l_data}, {3'd5, 3'd2});
        en = 3'b000;
        step();
        chk("abort_m", {m_valid, m_busy, m_done, m_data}, 0);
        chk("abort_l", {l_valid, l_busy, l_done, l_data}, 0);
        step();
        chk("abort_nodone", {m_done, l_done}, 0);

        en = 3'b100; load = 1'b1; data = 8'h00;
        step();
        load = 1'b0;
        chk("empty", {m_none, m_valid, m_busy, l_none}, 4'b1001);
        step();
        chk("empty_pulse", {m_none, l_none, m_valid}, 0);

        load = 1'b1; data = 8'hA5; ready = 1'b0;
        step();
        load = 1'b0;
        step();
        chk("rst_mid_pre", {m_valid, m_data}, {1'b1, 3'd7});
        rst_n = 1'b0;
        step();
        chk("rst_mid_m", {m_data, m_valid, m_busy, m_done, m_none}, 0);
        rst_n = 1'b1; ready = 1'b1;
        step();
        chk("rst_mid_after", {m_done, m_valid, l_done, l_valid}, 0);

        for (int v = 0; v < 256; v++) begin
            logic [7:0] acc_m, acc_l;
            int hs, prev_m;
            bit order_ok;
            acc_m = 8'h00; acc_l = 8'h00; hs = 0; prev_m = 8; order_ok = 1'b1;
            en = 3'b100; ready = 1'b1; load = 1'b1; data = 8'(v);
            step();
            load = 1'b0;
            while (m_valid && hs < 9) begin
                if (int'(m_data) >= prev_m) order_ok = 1'b0;
                prev_m = int'(m_data);
                acc_m |= dec(en, m_data);
                acc_l |= dec(en, l_data);
                hs++;
                step();
            end
            chk($sformatf("rt_m_%0d", v), acc_m, v);
            chk($sformatf("rt_l_%0d", v), acc_l, v);
            chk($sformatf("rt_hs_%0d", v), hs, $countones(8'(v)));
            chk($sformatf("rt_ord_%0d", v), order_ok, 1);
            chk($sformatf("rt_end_%0d", v), {m_done, m_none}, v == 0 ? 2'b01 : 2'b10);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
